ahb_decoder_mux: RTL
====================

Name: ahb_decoder_mux

Overview:
Parametrised AHB-Lite address decoder with an integrated data-phase response multiplexer and a built-in default slave.
- Decodes HADDR region bits into one-hot HSEL during the address phase.
- Registers the selected slave for the data phase and routes that slave's HRDATA/HREADYOUT/HRESP back to the master.
- Answers unmapped or disabled regions with a protocol-correct two-cycle ERROR response.
- Sits between the single AHB master and the slave array; it replaces the purely combinational decoder.

Parameters:
DATA_WIDTH, 32, read data width.
ADDRESS_WIDTH, 32, HADDR width.
NO_OF_SLAVES, 4, number of real slaves; legal range 1..2**SLAVE_ADDR_BITS.
SLAVE_ADDR_BITS, 4, number of top HADDR bits forming the region index.
SLAVE_EN, {NO_OF_SLAVES{1'b1}}, per-slave enable mask; a cleared bit makes that region unmapped.
ERR_CNT_WIDTH, 8, width of the saturating error counter.

Ports:
HCLK  input  1  system clock, all state on rising edge
HRESETn  input  1  asynchronous active-low reset
HADDR  input  ADDRESS_WIDTH  master address
HTRANS  input  2  master transfer type (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3)
HSEL  output  NO_OF_SLAVES  one-hot address-phase slave select
HRDATA_S  input  NO_OF_SLAVES*DATA_WIDTH  slave read data, slave i at bits [i*DATA_WIDTH +: DATA_WIDTH]
HREADYOUT_S  input  NO_OF_SLAVES  per-slave HREADYOUT
HRESP_S  input  NO_OF_SLAVES  per-slave HRESP (0 OKAY, 1 ERROR)
HRDATA  output  DATA_WIDTH  muxed read data to master
HREADY  output  1  muxed ready to master; also fed back to all slaves
HRESP  output  1  muxed response to master
ERR_COUNT  output  ERR_CNT_WIDTH  number of default-slave ERROR responses, saturating

Behaviour:
- Region index: idx = HADDR[ADDRESS_WIDTH-1 -: SLAVE_ADDR_BITS]. A region is mapped iff idx < NO_OF_SLAVES and SLAVE_EN[idx] = 1.
- HSEL is combinational from HADDR only and is not gated by HTRANS. It is one-hot at idx when mapped, all-zero otherwise.
- Data-phase owner register sel_q holds NO_OF_SLAVES+1 one-hot bits, with the extra bit for the default slave.
  - On a rising HCLK with HREADY = 1, sel_q loads {~mapped, HSEL}.
  - With HREADY = 0, sel_q holds.
- Output mux:
  - A real owner i drives HRDATA = slice i of HRDATA_S, HREADY = HREADYOUT_S[i], HRESP = HRESP_S[i].
  - The default-slave owner drives HRDATA = 0, and HREADY/HRESP come from the default FSM.
- Default slave FSM states: IDLE, ERR1, ERR2.
  - IDLE: HREADYOUT = 1, HRESP = 0. Goes to ERR1 when HREADY = 1, region unmapped and HTRANS[1] = 1. Stays in IDLE for IDLE/BUSY transfers, so those get a zero-wait OKAY.
  - ERR1: HREADYOUT = 0, HRESP = 1. Always goes to ERR2.
  - ERR2: HREADYOUT = 1, HRESP = 1. Goes to ERR1 if another unmapped NONSEQ/SEQ transfer is sampled this cycle; otherwise goes to IDLE.
- ERR_COUNT increments by 1 on every ERR1 -> ERR2 transition and saturates at all-ones.
- Reset (HRESETn low, asynchronous):
  - sel_q = default-slave owner; FSM = IDLE; ERR_COUNT = 0.
  - Hence HREADY = 1, HRESP = 0, HRDATA = 0. HSEL keeps following HADDR.
- Reset asserted mid-ERR1/ERR2 or mid-wait-state aborts immediately to the reset values above.
- Back-to-back transfers:
  - Mapped followed by unmapped: the mapped slave's data phase completes, then the default slave owns the bus; no bubble is inserted.
  - Unmapped followed by unmapped: the ERR2 -> ERR1 chain gives a two-cycle ERROR for each transfer.
- Slave wait states: while an owner holds HREADY low, HADDR/HTRANS changes have no effect on sel_q or the FSM. HSEL still follows HADDR combinationally.
- Elaboration-time check: NO_OF_SLAVES must be <= 2**SLAVE_ADDR_BITS and >= 1; otherwise raise a fatal error.

Decomposition:
- Shared package ahb_pkg holds:
  - HTRANS encodings (HTRANS_IDLE/BUSY/NONSEQ/SEQ) and HRESP encodings (HRESP_OKAY/ERROR).
  - Default-slave state enum (DS_IDLE, DS_ERR1, DS_ERR2).
- One sub-module, ahb_default_slave, contains the FSM and ERR_COUNT. Its inputs are HCLK, HRESETn, HREADY, HTRANS and the unmapped flag; its outputs are HREADYOUT, HRESP and ERR_COUNT.
- Decode, sel_q and the mux stay in the top module.

Test Plan:
- Reset, then idle bus -> HREADY = 1, HRESP = 0, HRDATA = 0x0, ERR_COUNT = 0, HSEL = 4'b0000 for HADDR = 0xF000_0000.
- NONSEQ read to 0x1000_0040 with slave 1 returning HRDATA 0xDEAD_BEEF after one wait state:
  - HSEL = 4'b0010 in the address phase.
  - Next cycle HREADY = 0; the cycle after, HREADY = 1 with HRDATA = 0xDEAD_BEEF.
- NONSEQ to 0x5000_0000 (unmapped) -> cycle 1 HREADY = 0, HRESP = 1; cycle 2 HREADY = 1, HRESP = 1; then ERR_COUNT = 1.
- IDLE transfer to 0x5000_0000 -> zero-wait OKAY, ERR_COUNT unchanged.
- SLAVE_EN = 4'b1011, NONSEQ to 0x2000_0000 -> HSEL = 4'b0000 and a two-cycle ERROR.
- Back-to-back sequence slave 0 -> unmapped -> slave 3, then HRESETn pulsed low during ERR1:
  - Data muxed correctly in each data phase.
  - On reset, outputs return immediately to HREADY = 1, HRESP = 0, ERR_COUNT = 0.

Source files
------------

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings and the default-slave state type used by the
// decoder/mux slice.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    DS_IDLE = 2'b00,
    DS_ERR1 = 2'b01,
    DS_ERR2 = 2'b10
  } ds_state_e;

endpackage

// File: rtl/ahb_default_slave.sv
// Default slave: answers unmapped NONSEQ/SEQ transfers with a two-cycle ERROR
// and keeps a saturating count of the ERROR responses it has issued.
module ahb_default_slave
  import ahb_pkg::*;
#(
  parameter int ERR_CNT_WIDTH = 8
) (
  input  logic                     HCLK,
  input  logic                     HRESETn,
  input  logic                     HREADY,
  input  logic [1:0]               HTRANS,
  input  logic                     unmapped,
  output logic                     HREADYOUT,
  output logic                     HRESP,
  output logic [ERR_CNT_WIDTH-1:0] ERR_COUNT
);

  localparam logic [ERR_CNT_WIDTH-1:0] CNT_ONE = ERR_CNT_WIDTH'(1);
  localparam logic [ERR_CNT_WIDTH-1:0] CNT_MAX = {ERR_CNT_WIDTH{1'b1}};

  ds_state_e                state_q, state_d;
  logic [ERR_CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic                     active_s;
  logic                     err_req_s;

  always_comb begin
    case (HTRANS)
      HTRANS_NONSEQ, HTRANS_SEQ: active_s = 1'b1;
      HTRANS_IDLE, HTRANS_BUSY:  active_s = 1'b0;
      default:                   active_s = 1'b0;
    endcase
  end

  // Only a completed address phase may start a new ERROR response.
  assign err_req_s = HREADY & unmapped & active_s;

  always_comb begin
    state_d   = state_q;
    err_cnt_d = err_cnt_q;
    case (state_q)
      DS_IDLE: state_d = err_req_s ? DS_ERR1 : DS_IDLE;
      DS_ERR1: begin
        state_d = DS_ERR2;
        if (err_cnt_q != CNT_MAX) begin
          err_cnt_d = err_cnt_q + CNT_ONE;
        end else begin
          err_cnt_d = err_cnt_q;
        end
      end
      DS_ERR2: state_d = err_req_s ? DS_ERR1 : DS_IDLE;
      default: state_d = DS_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q   <= DS_IDLE;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  always_comb begin
    case (state_q)
      DS_IDLE: begin HREADYOUT = 1'b1; HRESP = HRESP_OKAY;  end
      DS_ERR1: begin HREADYOUT = 1'b0; HRESP = HRESP_ERROR; end
      DS_ERR2: begin HREADYOUT = 1'b1; HRESP = HRESP_ERROR; end
      default: begin HREADYOUT = 1'b1; HRESP = HRESP_OKAY;  end
    endcase
  end

  assign ERR_COUNT = err_cnt_q;

endmodule

// File: rtl/ahb_decoder_mux.sv
// AHB-Lite address decoder with data-phase response mux and built-in default
// slave for unmapped or disabled regions.
module ahb_decoder_mux
  import ahb_pkg::*;
#(
  parameter int                      DATA_WIDTH      = 32,
  parameter int                      ADDRESS_WIDTH   = 32,
  parameter int                      NO_OF_SLAVES    = 4,
  parameter int                      SLAVE_ADDR_BITS = 4,
  parameter logic [NO_OF_SLAVES-1:0] SLAVE_EN        = {NO_OF_SLAVES{1'b1}},
  parameter int                      ERR_CNT_WIDTH   = 8
) (
  input  logic                               HCLK,
  input  logic                               HRESETn,
  input  logic [ADDRESS_WIDTH-1:0]           HADDR,
  input  logic [1:0]                         HTRANS,
  output logic [NO_OF_SLAVES-1:0]            HSEL,
  input  logic [NO_OF_SLAVES*DATA_WIDTH-1:0] HRDATA_S,
  input  logic [NO_OF_SLAVES-1:0]            HREADYOUT_S,
  input  logic [NO_OF_SLAVES-1:0]            HRESP_S,
  output logic [DATA_WIDTH-1:0]              HRDATA,
  output logic                               HREADY,
  output logic                               HRESP,
  output logic [ERR_CNT_WIDTH-1:0]           ERR_COUNT
);

  localparam int                SEL_W       = NO_OF_SLAVES + 1;
  localparam logic [SEL_W-1:0]  SEL_DEFAULT = {1'b1, {NO_OF_SLAVES{1'b0}}};

  if ((NO_OF_SLAVES < 1) || (NO_OF_SLAVES > (2 ** SLAVE_ADDR_BITS))) begin : g_param_check
    $fatal(1, "ahb_decoder_mux: NO_OF_SLAVES must be in 1..2**SLAVE_ADDR_BITS");
  end

  logic [SLAVE_ADDR_BITS-1:0] idx_s;
  logic [NO_OF_SLAVES-1:0]    hsel_s;
  logic                       mapped_s;
  logic [SEL_W-1:0]           sel_q, sel_d;
  logic                       ds_hreadyout_s;
  logic                       ds_hresp_s;
  logic [DATA_WIDTH-1:0]      rdata_s;
  logic                       ready_s;
  logic                       resp_s;
  logic                       unused_addr_s;

  assign idx_s         = HADDR[ADDRESS_WIDTH-1 -: SLAVE_ADDR_BITS];
  assign unused_addr_s = ^HADDR[ADDRESS_WIDTH-SLAVE_ADDR_BITS-1:0];

  // Disabled or out-of-range regions simply never assert a select bit.
  always_comb begin
    hsel_s = '0;
    for (int i = 0; i < NO_OF_SLAVES; i++) begin
      hsel_s[i] = (idx_s == SLAVE_ADDR_BITS'(i)) & SLAVE_EN[i];
    end
  end

  assign mapped_s = |hsel_s;
  assign HSEL     = hsel_s;

  always_comb begin
    if (HREADY) begin
      sel_d = {~mapped_s, hsel_s};
    end else begin
      sel_d = sel_q;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      sel_q <= SEL_DEFAULT;
    end else begin
      sel_q <= sel_d;
    end
  end

  ahb_default_slave #(
    .ERR_CNT_WIDTH(ERR_CNT_WIDTH)
  ) u_default_slave (
    .HCLK      (HCLK),
    .HRESETn   (HRESETn),
    .HREADY    (HREADY),
    .HTRANS    (HTRANS),
    .unmapped  (~mapped_s),
    .HREADYOUT (ds_hreadyout_s),
    .HRESP     (ds_hresp_s),
    .ERR_COUNT (ERR_COUNT)
  );

  // sel_q is one-hot, so an AND-OR mux is exact; the default slave returns zero data.
  always_comb begin
    rdata_s = '0;
    ready_s = ds_hreadyout_s & sel_q[NO_OF_SLAVES];
    resp_s  = ds_hresp_s & sel_q[NO_OF_SLAVES];
    for (int i = 0; i < NO_OF_SLAVES; i++) begin
      rdata_s = rdata_s | (HRDATA_S[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{sel_q[i]}});
      ready_s = ready_s | (HREADYOUT_S[i] & sel_q[i]);
      resp_s  = resp_s  | (HRESP_S[i] & sel_q[i]);
    end
  end

  assign HRDATA = rdata_s;
  assign HREADY = ready_s;
  assign HRESP  = resp_s;

endmodule
